// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with double-buffered period/high time and drain control.
// Optional phase-realign input `sync` is present when CLK_DIV_SYNC_EN is defined.
module clk_div_prog #(
    parameter int WIDTH    = 16,
    parameter int DIV_RST  = 256,
    parameter int HIGH_RST = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             pending,
    output logic             upd_done
);

    localparam logic [WIDTH-1:0] DIV_RST_W  = WIDTH'(DIV_RST);
    localparam logic [WIDTH-1:0] HIGH_RST_W = WIDTH'(HIGH_RST);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] div_a_reg, div_a_next;
    logic [WIDTH-1:0] high_a_reg, high_a_next;
    logic [WIDTH-1:0] div_s_reg, div_s_next;
    logic [WIDTH-1:0] high_s_reg, high_s_next;
    logic             pending_reg, pending_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg, tick_next;
    logic             upd_done_reg, upd_done_next;

    logic [WIDTH-1:0] div_c, high_c, cnt_inc;
    logic             sync_hit, wrap;

    // Clamp at capture so stored values are always legal: div >= 2, 1 <= high < div.
    always_comb begin
        div_c  = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
        high_c = (high_in == '0) ? WIDTH'(1) : high_in;
        if (high_c >= div_c)
            high_c = div_c - WIDTH'(1);
    end

`ifdef CLK_DIV_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    assign cnt_inc = cnt_reg + WIDTH'(1);
    assign wrap    = (cnt_reg == div_a_reg - WIDTH'(1)) || sync_hit;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        div_a_next    = div_a_reg;
        high_a_next   = high_a_reg;
        div_s_next    = div_s_reg;
        high_s_next   = high_s_reg;
        pending_next  = pending_reg;
        clk_out_next  = clk_out_reg;
        tick_next     = 1'b0;
        upd_done_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (load) begin
                    div_a_next    = div_c;
                    high_a_next   = high_c;
                    div_s_next    = div_c;
                    high_s_next   = high_c;
                    upd_done_next = 1'b1;
                end
                cnt_next = '0;
                if (en) begin
                    state_next   = RUN;
                    clk_out_next = 1'b1;
                    tick_next    = 1'b1;
                end else begin
                    clk_out_next = 1'b0;
                end
            end
            RUN, DRAIN: begin
                if (wrap) begin
                    cnt_next = '0;
                    // A load coinciding with the boundary bypasses the shadow wait.
                    if (load) begin
                        div_a_next    = div_c;
                        high_a_next   = high_c;
                        div_s_next    = div_c;
                        high_s_next   = high_c;
                        pending_next  = 1'b0;
                        upd_done_next = 1'b1;
                    end else if (pending_reg) begin
                        div_a_next    = div_s_reg;
                        high_a_next   = high_s_reg;
                        pending_next  = 1'b0;
                        upd_done_next = 1'b1;
                    end
                    if (en) begin
                        state_next   = RUN;
                        clk_out_next = 1'b1;
                        tick_next    = 1'b1;
                    end else begin
                        state_next   = IDLE;
                        clk_out_next = 1'b0;
                    end
                end else begin
                    cnt_next     = cnt_inc;
                    clk_out_next = (cnt_inc < high_a_reg);
                    state_next   = en ? RUN : DRAIN;
                    if (load) begin
                        div_s_next   = div_c;
                        high_s_next  = high_c;
                        pending_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                cnt_next     = '0;
                clk_out_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            div_a_reg    <= DIV_RST_W;
            high_a_reg   <= HIGH_RST_W;
            div_s_reg    <= DIV_RST_W;
            high_s_reg   <= HIGH_RST_W;
            pending_reg  <= 1'b0;
            clk_out_reg  <= 1'b0;
            tick_reg     <= 1'b0;
            upd_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            div_a_reg    <= div_a_next;
            high_a_reg   <= high_a_next;
            div_s_reg    <= div_s_next;
            high_s_reg   <= high_s_next;
            pending_reg  <= pending_next;
            clk_out_reg  <= clk_out_next;
            tick_reg     <= tick_next;
            upd_done_reg <= upd_done_next;
        end
    end

    assign clk_out  = clk_out_reg;
    assign tick     = tick_reg;
    assign busy     = (state_reg != IDLE);
    assign pending  = pending_reg;
    assign upd_done = upd_done_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: vector table plus hand-built multi-cycle sequences.
// Build with +define+CLK_DIV_SYNC_EN to exercise the phase-realign input.
module tb_clk_div_prog;

    typedef struct packed {
        logic clk_out;
        logic tick;
        logic busy;
        logic pending;
        logic upd_done;
    } obs_t;

    typedef struct {
        logic        en;
        logic        load;
        logic [15:0] d;
        logic [15:0] h;
        obs_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] div_in = '0;
    logic [15:0] high_in = '0;
    logic        sync = 1'b0;
    logic        clk_out, tick, busy, pending, upd_done;

    int   n_tests = 0;
    int   n_fail = 0;
    obs_t exp_q[$];
    vec_t vecs[$];

    clk_div_prog #(.WIDTH(16), .DIV_RST(256), .HIGH_RST(128)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .div_in   (div_in),
        .high_in  (high_in),
`ifdef CLK_DIV_SYNC_EN
        .sync     (sync),
`endif
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy),
        .pending  (pending),
        .upd_done (upd_done)
    );

    always #5 clk = ~clk;

    function automatic obs_t ob(input logic c, input logic t, input logic b,
                                input logic p, input logic u);
        return {c, t, b, p, u};
    endfunction

    function automatic vec_t mkv(input logic e, input logic l, input int d, input int h,
                                 input obs_t x);
        vec_t v;
        v.en = e; v.load = l; v.d = 16'(d); v.h = 16'(h); v.exp = x;
        return v;
    endfunction

    function automatic obs_t sample();
        return {clk_out, tick, busy, pending, upd_done};
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input logic e, input logic l, input int d, input int h,
                        input obs_t ex, input string nm);
        obs_t got, want;
        en = e; load = l; div_in = 16'(d); high_in = 16'(h);
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        got  = sample();
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s t=%0t got(clk,tick,busy,pend,upd)=%b want=%b", nm, $time, got, want);
        end else begin
            $display("[TB] ok %s t=%0t obs=%b", nm, $time, got);
        end
        load = 1'b0;
    endtask

    // Steady running at a known phase: expectation is position-in-period based.
    task automatic run_periodic(input int dv, input int hv, input int start, input int n,
                                input logic pend, input string nm);
        for (int i = 0; i < n; i++) begin
            int c;
            c = (start + i) % dv;
            step(1'b1, 1'b0, 0, 0, ob(c < hv, c == 0, 1'b1, pend, 1'b0), nm);
        end
    endtask

    task automatic do_reset(input string nm);
        obs_t got;
        en = 1'b0; load = 1'b0; sync = 1'b0;
        reset = 1'b1;
        #1;
        got = sample();
        n_tests++;
        if (got !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL %s async reset got=%b want=00000", nm, got);
        end else begin
            $display("[TB] ok %s async reset obs=%b", nm, got);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Defaults after reset: 256/128, first rise one cycle after en.
        do_reset("reset_init");
        step(1'b1, 1'b0, 0, 0, ob(1, 1, 1, 0, 0), "dflt_start");
        run_periodic(256, 128, 1, 300, 1'b0, "dflt_run");
        // Currently cnt=44 (high): reset must drop outputs immediately.
        do_reset("reset_mid_high");

        // Table: IDLE load 5/2 then run.
        vecs.push_back(mkv(1'b0, 1'b1, 5, 2, ob(0, 0, 0, 0, 1)));
        vecs.push_back(mkv(1'b1, 1'b0, 0, 0, ob(1, 1, 1, 0, 0)));
        for (int i = 1; i < 16; i++) begin
            int c;
            c = i % 5;
            vecs.push_back(mkv(1'b1, 1'b0, 0, 0, ob(c < 2, c == 0, 1, 0, 0)));
        end
        foreach (vecs[i])
            step(vecs[i].en, vecs[i].load, int'(vecs[i].d), int'(vecs[i].h), vecs[i].exp,
                 $sformatf("vec%0d", i));

        // Deferred update: 10/5 running, load 4/1 at cnt=3.
        do_reset("reset_defer");
        step(1'b0, 1'b1, 10, 5, ob(0, 0, 0, 0, 1), "defer_idle_load");
        step(1'b1, 1'b0, 0, 0, ob(1, 1, 1, 0, 0), "defer_start");
        run_periodic(10, 5, 1, 3, 1'b0, "defer_run");
        step(1'b1, 1'b1, 4, 1, ob(1, 0, 1, 1, 0), "defer_load");
        run_periodic(10, 5, 5, 5, 1'b1, "defer_pending");
        step(1'b1, 1'b0, 0, 0, ob(1, 1, 1, 0, 1), "defer_wrap");
        run_periodic(4, 1, 1, 11, 1'b0, "defer_new");

        // Clamp high>=div, last-wins shadow, clamp 0/0, load coincident with wrap.
        do_reset("reset_clamp");
        step(1'b0, 1'b1, 6, 9, ob(0, 0, 0, 0, 1), "clamp_6_9");
        step(1'b1, 1'b0, 0, 0, ob(1, 1, 1, 0, 0), "clamp_start");
        run_periodic(6, 5, 1, 9, 1'b0, "clamp_run65");
        step(1'b1, 1'b1, 3, 1, ob(1, 0, 1, 1, 0), "shadow_first");
        step(1'b1, 1'b1, 0, 0, ob(0, 0, 1, 1, 0), "shadow_second");
        step(1'b1, 1'b0, 0, 0, ob(1, 1, 1, 0, 1), "shadow_wrap");
        run_periodic(2, 1, 1, 5, 1'b0, "clamp_run21");
        step(1'b1, 1'b1, 3, 1, ob(1, 1, 1, 0, 1), "load_at_wrap");
        run_periodic(3, 1, 1, 6, 1'b0, "run31");

        // Drain: 8/4, drop en at cnt=2, period completes, then idle.
        do_reset("reset_drain");
        step(1'b0, 1'b1, 8, 4, ob(0, 0, 0, 0, 1), "drain_load");
        step(1'b1, 1'b0, 0, 0, ob(1, 1, 1, 0, 0), "drain_start");
        run_periodic(8, 4, 1, 1, 1'b0, "drain_run");
        for (int c = 2; c < 8; c++)
            step(1'b0, 1'b0, 0, 0, ob(c < 4, 1'b0, 1, 0, 0), $sformatf("drain_cnt%0d", c));
        step(1'b0, 1'b0, 0, 0, ob(0, 0, 0, 0, 0), "drain_idle");
        step(1'b0, 1'b0, 0, 0, ob(0, 0, 0, 0, 0), "drain_stay_idle");
        // Re-enable inside DRAIN: phase continues.
        step(1'b1, 1'b0, 0, 0, ob(1, 1, 1, 0, 0), "redrain_start");
        run_periodic(8, 4, 1, 2, 1'b0, "redrain_run");
        step(1'b0, 1'b0, 0, 0, ob(1, 0, 1, 0, 0), "redrain_drop");
        run_periodic(8, 4, 4, 8, 1'b0, "redrain_resume");

`ifdef CLK_DIV_SYNC_EN
        // Sync at cnt=5 realigns phase on the next edge; ignored in IDLE.
        do_reset("reset_sync");
        sync = 1'b1;
        step(1'b0, 1'b1, 8, 4, ob(0, 0, 0, 0, 1), "sync_idle_ignored");
        sync = 1'b0;
        step(1'b1, 1'b0, 0, 0, ob(1, 1, 1, 0, 0), "sync_start");
        run_periodic(8, 4, 1, 5, 1'b0, "sync_run");
        sync = 1'b1;
        step(1'b1, 1'b0, 0, 0, ob(1, 1, 1, 0, 0), "sync_realign");
        sync = 1'b0;
        run_periodic(8, 4, 1, 9, 1'b0, "sync_after");
`endif

        do_reset("reset_final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
